bus_responder: RTL
==================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter DATA_W, default 8: request write-data and response read-data width.
REQ-002 Parameter ADDR_W, default 4: request address width.
REQ-003 Parameter DEPTH, default 8: register-file entries; addresses >= DEPTH are out of range.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  target entry.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  response held on rsp_* outputs.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  request addressed an out-of-range entry.
REQ-015 txn_cnt  output  8  count of completed responses.
REQ-016 err_cnt  output  8  error counter; present only with BUS_RSP_ERRCNT_EN.

Function
REQ-017 The block SHALL be the responder end of the request/response bus: it accepts requests and returns exactly one response per accepted request, in order.
REQ-018 The request handshake SHALL be: accept = req_valid && req_ready; req_ready = !rsp_valid || rsp_ready (combinational path from rsp_ready).
REQ-019 The response handshake SHALL be: complete = rsp_valid && rsp_ready.
REQ-020 The state machine SHALL have states IDLE (rsp_valid=0) and RESP (rsp_valid=1): IDLE->RESP on accept; RESP->IDLE on complete without accept; RESP->RESP on complete with accept (back-to-back).
REQ-021 The response SHALL appear on the clock edge that accepts the request (latency 1 cycle) and SHALL hold rsp_rdata and rsp_err stable until complete.
REQ-022 An in-range write SHALL update mem[addr] on the accept edge; its response has rsp_rdata=0 and rsp_err=0.
REQ-023 An in-range read SHALL return mem[addr] as stored before the accept edge; a write accepted on the preceding cycle SHALL be visible.
REQ-024 An out-of-range request (addr >= DEPTH) SHALL leave memory unchanged and respond with rsp_err=1 and rsp_rdata=0.
REQ-025 When req_valid=1 and req_ready=0, the request SHALL be neither accepted nor altered; the initiator holds it.
REQ-026 txn_cnt SHALL increment by 1 on each complete and wrap from 255 to 0.
REQ-027 Input changes while req_valid=0 SHALL have no effect.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL return to IDLE and set rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_cnt=0, err_cnt=0, and all mem entries to 0.
REQ-029 Reset during RESP SHALL drop the pending response without incrementing the counters; req_ready SHALL be 1 on the first cycle after reset releases.

Configuration
REQ-030 With macro BUS_RSP_ERRCNT_EN defined, the block SHALL have port err_cnt, which increments on each complete with rsp_err=1 and saturates at 255.
REQ-031 Without BUS_RSP_ERRCNT_EN, port err_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Write addr=3 data=0xA5, then read addr=3, with rsp_ready=1 -> write rsp rdata=0x00 err=0; read rsp rdata=0xA5 err=0; txn_cnt=2.
REQ-033 Read addr=9 (DEPTH=8) -> rsp_err=1, rsp_rdata=0x00, memory unchanged; with macro err_cnt=1.
REQ-034 rsp_ready=0 for 4 cycles after a read of addr=3 -> rsp_valid stays 1 and rdata stays 0xA5; req_ready=0; a held write to addr=3 is not applied until the response completes.
REQ-035 Streamed writes addr 0..7 with data 0x10..0x17 and rsp_ready=1 -> one accept per cycle, req_ready never drops; reads of addr 0..7 then return 0x10..0x17.
REQ-036 Assert rst_n=0 while in RESP -> next cycle rsp_valid=0, txn_cnt=0, and a read of addr=3 returns 0x00; also 256 completions -> txn_cnt wraps to 0.

Source files
------------

// File: rtl/bus_responder.sv
// Single-outstanding request/response responder backed by a small register file.
// Optional BUS_RSP_ERRCNT_EN adds a saturating error counter on port err_cnt.
module bus_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        txn_cnt
`ifdef BUS_RSP_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              complete;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign accept   = req_valid && req_ready;
  assign complete = rsp_valid && rsp_ready;
  assign in_range = 32'(req_addr) < DEPTH_U;
  assign idx      = IDX_W'(req_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RESP;
      RESP:    if (complete && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is combinational on rsp_ready so a completing response frees the slot the same cycle.
  always_comb begin
    rsp_valid = (state == RESP);
    req_ready = !rsp_valid || rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) mem[i] <= '0;
    end else if (accept && req_write && in_range) begin
      mem[idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= !in_range;
      rsp_rdata <= (!req_write && in_range) ? mem[idx] : '0;
    end else if (complete) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        txn_cnt <= '0;
    else if (complete) txn_cnt <= txn_cnt + 8'd1;
  end

`ifdef BUS_RSP_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                    err_cnt <= '0;
    else if (complete && rsp_err && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
